// File: rtl/pixel_mixer.sv
// pixel_mixer: priority overlay mixer with frame-synchronous configuration.
// Picks the lowest-index enabled+valid layer (else background, 0 when blanked),
// carries it through PIPE_DEPTH p_tick-enabled registers alongside hsync/vsync,
// and applies configuration writes only at the vsync assertion edge.
// Ports:
//   clk_100MHz, reset                 clock, async active-high reset
//   p_tick                            pixel enable
//   video_on, hsync_in, vsync_in      timing generator inputs
//   layer_rgb, layer_valid            per-layer colour and coverage
//   cfg_wr, cfg_layer_en, cfg_bg_color configuration write port
//   rgb, hsync, vsync                 pixel-aligned outputs
//   cfg_pending, frame_tick           configuration status
module pixel_mixer #(
   parameter int unsigned NUM_LAYERS      = 2,
   parameter int unsigned COLOR_BITS      = 12,
   parameter int unsigned PIPE_DEPTH      = 2,
   parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
   input  logic                             clk_100MHz,
   input  logic                             reset,
   input  logic                             p_tick,
   input  logic                             video_on,
   input  logic                             hsync_in,
   input  logic                             vsync_in,
   input  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_rgb,
   input  logic [NUM_LAYERS-1:0]            layer_valid,
   input  logic                             cfg_wr,
   input  logic [NUM_LAYERS-1:0]            cfg_layer_en,
   input  logic [COLOR_BITS-1:0]            cfg_bg_color,
   output logic [COLOR_BITS-1:0]            rgb,
   output logic                             hsync,
   output logic                             vsync,
   output logic                             cfg_pending,
   output logic                             frame_tick
);

   localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

   logic [COLOR_BITS-1:0] col_q [PIPE_DEPTH];
   logic [COLOR_BITS-1:0] col_d [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] hs_q, hs_d, vs_q, vs_d;
   logic                  vs_prev_q, vs_prev_d;
   logic [NUM_LAYERS-1:0] act_en_q, act_en_d, pend_en_q, pend_en_d;
   logic [COLOR_BITS-1:0] act_bg_q, act_bg_d, pend_bg_q, pend_bg_d;
   logic                  pending_q, pending_d;
   logic                  frame_tick_q, frame_tick_d;
   logic [COLOR_BITS-1:0] mix_c;
   logic                  found_c;
   logic                  apply_c;

   // Stage 0 priority select: lowest index wins, blanking forces black.
   always_comb begin
      mix_c   = act_bg_q;
      found_c = 1'b0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         if (!found_c && act_en_q[i] && layer_valid[i]) begin
            mix_c   = layer_rgb[i*COLOR_BITS +: COLOR_BITS];
            found_c = 1'b1;
         end
      end
      if (!video_on) mix_c = '0;
   end

   // Colour and sync delay lines share one enable so they stay aligned.
   always_comb begin
      col_d = col_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      if (p_tick) begin
         col_d[0] = mix_c;
         hs_d[0]  = hsync_in;
         vs_d[0]  = vsync_in;
         for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            col_d[i] = col_q[i-1];
            hs_d[i]  = hs_q[i-1];
            vs_d[i]  = vs_q[i-1];
         end
      end
   end

   // Configuration: a frame boundary applies the old pending set before a
   // coincident write lands, so that write stays pending for the next frame.
   always_comb begin
      vs_prev_d    = vs_prev_q;
      act_en_d     = act_en_q;
      act_bg_d     = act_bg_q;
      pend_en_d    = pend_en_q;
      pend_bg_d    = pend_bg_q;
      pending_d    = pending_q;
      apply_c      = p_tick && (vs_prev_q == SYNC_OFF) && (vsync_in != SYNC_OFF)
                     && pending_q;
      frame_tick_d = apply_c;
      if (p_tick) vs_prev_d = vsync_in;
      if (apply_c) begin
         act_en_d  = pend_en_q;
         act_bg_d  = pend_bg_q;
         pending_d = 1'b0;
      end
      if (cfg_wr) begin
         pend_en_d = cfg_layer_en;
         pend_bg_d = cfg_bg_color;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) col_q[i] <= '0;
         hs_q         <= {PIPE_DEPTH{SYNC_OFF}};
         vs_q         <= {PIPE_DEPTH{SYNC_OFF}};
         vs_prev_q    <= SYNC_OFF;
         act_en_q     <= '1;
         act_bg_q     <= '0;
         pend_en_q    <= '0;
         pend_bg_q    <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         vs_prev_q    <= vs_prev_d;
         act_en_q     <= act_en_d;
         act_bg_q     <= act_bg_d;
         pend_en_q    <= pend_en_d;
         pend_bg_q    <= pend_bg_d;
         pending_q    <= pending_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign rgb         = col_q[PIPE_DEPTH-1];
   assign hsync       = hs_q[PIPE_DEPTH-1];
   assign vsync       = vs_q[PIPE_DEPTH-1];
   assign cfg_pending = pending_q;
   assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_pixel_mixer.sv
// tb_pixel_mixer: directed bench for pixel_mixer with default parameters.
// Expected pixels are pushed to a scoreboard queue when driven and popped
// when the pipeline delivers them; a reference config model tracks frames.
module tb_pixel_mixer;

   localparam int unsigned NL = 2;
   localparam int unsigned CB = 12;
   localparam int unsigned PD = 2;

   typedef struct packed {
      logic [CB-1:0] c;
      logic          h;
      logic          v;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           p_tick = 1'b0;
   logic           video_on = 1'b0;
   logic           hsync_in = 1'b1;
   logic           vsync_in = 1'b1;
   logic [NL*CB-1:0] layer_rgb = '0;
   logic [NL-1:0]  layer_valid = '0;
   logic           cfg_wr = 1'b0;
   logic [NL-1:0]  cfg_layer_en = '0;
   logic [CB-1:0]  cfg_bg_color = '0;
   logic [CB-1:0]  rgb;
   logic           hsync, vsync, cfg_pending, frame_tick;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   // Reference configuration model
   logic [NL-1:0] m_en, m_pen;
   logic [CB-1:0] m_bg, m_pbg;
   logic          m_pend, m_vsprev;

   pixel_mixer #(.NUM_LAYERS(NL), .COLOR_BITS(CB), .PIPE_DEPTH(PD), .SYNC_ACTIVE_LOW(1)) dut (
      .clk_100MHz(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_rgb(layer_rgb),
      .layer_valid(layer_valid), .cfg_wr(cfg_wr), .cfg_layer_en(cfg_layer_en),
      .cfg_bg_color(cfg_bg_color), .rgb(rgb), .hsync(hsync), .vsync(vsync),
      .cfg_pending(cfg_pending), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      exp_t r;
      @(negedge clk);
      reset = 1'b1;
      #2;
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_hsync", 32'(hsync), 32'h1);
      chk("rst_vsync", 32'(vsync), 32'h1);
      chk("rst_pending", 32'(cfg_pending), 32'h0);
      chk("rst_ftick", 32'(frame_tick), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_en = '1; m_bg = '0; m_pen = '0; m_pbg = '0; m_pend = 1'b0; m_vsprev = 1'b1;
      sb.delete();
      r = '{c: '0, h: 1'b1, v: 1'b1};
      for (int i = 0; i < int'(PD) - 1; i++) sb.push_back(r);
   endtask

   task automatic cfg_write(input logic [NL-1:0] en, input logic [CB-1:0] bg);
      cfg_wr = 1'b1; cfg_layer_en = en; cfg_bg_color = bg;
      @(posedge clk);
      #1;
      cfg_wr = 1'b0;
      m_pen = en; m_pbg = bg; m_pend = 1'b1;
      chk("cfgwr_pending", 32'(cfg_pending), 32'h1);
      chk("cfgwr_ftick", 32'(frame_tick), 32'h0);
   endtask

   // One pixel: drive, tick, compare the pixel leaving the pipeline.
   task automatic pix(input logic vid, input logic hs, input logic vs,
                      input logic [NL*CB-1:0] lrgb, input logic [NL-1:0] lv,
                      input logic wr = 1'b0, input logic [NL-1:0] wen = '0,
                      input logic [CB-1:0] wbg = '0);
      exp_t e;
      logic [CB-1:0] c;
      logic ft_exp;
      c = m_bg;
      if (m_en[0] && lv[0]) c = lrgb[CB-1:0];
      else if (m_en[1] && lv[1]) c = lrgb[2*CB-1:CB];
      if (!vid) c = '0;
      sb.push_back('{c: c, h: hs, v: vs});
      ft_exp = m_vsprev && !vs && m_pend;
      video_on = vid; hsync_in = hs; vsync_in = vs; layer_rgb = lrgb; layer_valid = lv;
      cfg_wr = wr; cfg_layer_en = wen; cfg_bg_color = wbg;
      p_tick = 1'b1;
      @(posedge clk);
      #1;
      p_tick = 1'b0; cfg_wr = 1'b0;
      m_vsprev = vs;
      if (ft_exp) begin m_en = m_pen; m_bg = m_pbg; m_pend = 1'b0; end
      if (wr) begin m_pen = wen; m_pbg = wbg; m_pend = 1'b1; end
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL sb_empty observed=0 expected=entry");
         e = '0;
      end else e = sb.pop_front();
      chk("rgb", 32'(rgb), 32'(e.c));
      chk("hsync", 32'(hsync), 32'(e.h));
      chk("vsync", 32'(vsync), 32'(e.v));
      chk("frame_tick", 32'(frame_tick), 32'(ft_exp));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
      @(posedge clk);
      #1;
      chk("ftick_width", 32'(frame_tick), 32'h0);
      chk("rgb_hold", 32'(rgb), 32'(e.c));
      @(posedge clk);
      @(posedge clk);
      #1;
   endtask

   localparam logic [NL*CB-1:0] L_BOTH = {12'h0F0, 12'hF00};

   initial begin
      int hlow;
      logic [NL*CB-1:0] rl;
      #3;
      do_reset();

      // Default priority: layer0 wins, then layer1 alone
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b10);

      // Load background 00F across a frame boundary
      cfg_write(2'b11, 12'h00F);
      pix(1'b0, 1'b1, 1'b0, L_BOTH, 2'b11);
      pix(1'b0, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b00);
      repeat (3) pix(1'b0, 1'b1, 1'b1, L_BOTH, 2'b00);

      // Mid-frame config holds until vsync edge, then layer0 is masked
      cfg_write(2'b10, 12'h333);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b11);
      pix(1'b0, 1'b1, 1'b0, L_BOTH, 2'b11);
      pix(1'b0, 1'b1, 1'b0, L_BOTH, 2'b11);
      pix(1'b0, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b01);

      // 96-pixel hsync pulse with random pixels
      hlow = 0;
      for (int i = 0; i < 110; i++) begin
         rl = {12'($urandom), 12'($urandom)};
         pix(1'b1, !(i >= 5 && i < 101), 1'b1, rl, 2'($urandom));
         if (hsync == 1'b0) hlow++;
      end
      chk("hsync_width", 32'(hlow), 32'd96);

      // Write coinciding with an applying boundary stays pending
      cfg_write(2'b01, 12'hABC);
      pix(1'b0, 1'b1, 1'b0, L_BOTH, 2'b11, 1'b1, 2'b11, 12'h111);
      pix(1'b0, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b10);
      pix(1'b0, 1'b1, 1'b0, L_BOTH, 2'b11);
      pix(1'b0, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b00);
      // Boundary without pending config leaves things alone
      pix(1'b0, 1'b1, 1'b0, L_BOTH, 2'b11);
      pix(1'b0, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b00);

      // Reset mid-line with pending config
      cfg_write(2'b01, 12'h555);
      repeat (3) pix(1'b1, 1'b0, 1'b1, L_BOTH, 2'b10);
      do_reset();
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b11);
      repeat (3) pix(1'b1, 1'b1, 1'b1, L_BOTH, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_mixer.md
PIXEL_MIXER -- requirements
Module: pixel_mixer

Interface
REQ-001 Parameter NUM_LAYERS, default 2: number of overlay layers, legal range 1..8.
REQ-002 Parameter COLOR_BITS, default 12: width of each layer colour and of rgb (4:4:4).
REQ-003 Parameter PIPE_DEPTH, default 2: pixel-tick pipeline depth, legal range 1..4.
REQ-004 Parameter SYNC_ACTIVE_LOW, default 1: sync polarity; 1 = hsync/vsync asserted low.
REQ-005 clk_100MHz  input  1  system clock; the only clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 p_tick  input  1  pixel enable, one clk_100MHz cycle wide, one per pixel.
REQ-008 video_on  input  1  active-display flag from the timing generator.
REQ-009 hsync_in  input  1  horizontal sync from the timing generator.
REQ-010 vsync_in  input  1  vertical sync from the timing generator.
REQ-011 layer_rgb  input  NUM_LAYERS*COLOR_BITS  layer colours; layer i occupies bits [i*COLOR_BITS +: COLOR_BITS].
REQ-012 layer_valid  input  NUM_LAYERS  per-layer pixel-covered flag for the current pixel.
REQ-013 cfg_wr  input  1  single-cycle configuration write strobe.
REQ-014 cfg_layer_en  input  NUM_LAYERS  requested layer enables, captured on cfg_wr.
REQ-015 cfg_bg_color  input  COLOR_BITS  requested background colour, captured on cfg_wr.
REQ-016 rgb  output  COLOR_BITS  registered output colour to the DAC.
REQ-017 hsync  output  1  hsync_in delayed to align with rgb.
REQ-018 vsync  output  1  vsync_in delayed to align with rgb.
REQ-019 cfg_pending  output  1  high while a captured configuration awaits the frame boundary.
REQ-020 frame_tick  output  1  one-clk pulse when pending configuration becomes active.

Function
REQ-021 All state other than the configuration registers SHALL advance only in clk_100MHz cycles where p_tick=1; with p_tick=0, every pipeline register SHALL hold.
REQ-022 Stage 0 SHALL select the lowest index i with active_en[i]=1 and layer_valid[i]=1; with no such layer it SHALL select active_bg.
REQ-023 If video_on=0 at the sampling p_tick, stage 0 SHALL produce 0 regardless of layers.
REQ-024 The colour SHALL pass through PIPE_DEPTH registers; rgb SHALL reflect the inputs sampled PIPE_DEPTH p_ticks earlier.
REQ-025 hsync_in and vsync_in SHALL pass through an identical PIPE_DEPTH-stage p_tick-enabled delay line, so that hsync, vsync and rgb stay pixel-aligned.
REQ-026 On cfg_wr=1, cfg_layer_en and cfg_bg_color SHALL be captured into pending registers and cfg_pending SHALL be set on the next clk edge.
REQ-027 A frame boundary SHALL be the p_tick at which the sampled vsync_in moves from deasserted to asserted (per SYNC_ACTIVE_LOW).
REQ-028 At a frame boundary with cfg_pending=1, the pending values SHALL be copied into active_en/active_bg, cfg_pending SHALL clear, and frame_tick SHALL pulse for exactly one clk cycle.
REQ-029 At a frame boundary with cfg_pending=0, active configuration SHALL be unchanged and frame_tick SHALL stay 0.
REQ-030 If cfg_wr coincides with an applying frame boundary, the previous pending values SHALL be applied, the new values SHALL become pending, and cfg_pending SHALL remain 1.
REQ-031 Repeated cfg_wr before a boundary SHALL overwrite pending values; only the most recent write applies.
REQ-032 Active configuration SHALL never change mid-frame.

Reset
REQ-033 While reset=1: rgb=0, every colour stage=0, every sync stage and hsync/vsync=deasserted level, the sync-edge sampler=deasserted level.
REQ-034 While reset=1: active_en=all ones, active_bg=0, pending registers=0, cfg_pending=0, frame_tick=0.
REQ-035 Reset asserted mid-frame or mid-pipeline SHALL discard all in-flight pixels and pending configuration without glitching hsync/vsync to the asserted level.

Verification
REQ-036 Defaults, layer0=12'hF00 valid, layer1=12'h0F0 valid, video_on=1 -> rgb=12'hF00 exactly 2 p_ticks later; with only layer1 valid -> 12'h0F0.
REQ-037 No layer valid, video_on=1, active_bg=12'h00F -> rgb=12'h00F; video_on=0 -> rgb=0.
REQ-038 cfg_wr mid-frame with cfg_layer_en=2'b10, cfg_bg_color=12'h333 -> cfg_pending=1, output unchanged until vsync assertion edge, then frame_tick pulses once and layer0 is ignored.
REQ-039 hsync_in pulse of 96 p_ticks with p_tick every 4th clk -> hsync pulse of 96 p_ticks, delayed by PIPE_DEPTH p_ticks, aligned with rgb.
REQ-040 cfg_wr on the same clk as an applying boundary -> old pending applied, new held, cfg_pending=1 until the next frame boundary.
REQ-041 reset pulsed mid-line with cfg_pending=1 -> rgb=0, hsync=vsync=1, cfg_pending=0, active_en=all ones.
